nx_ram_1rw_port_ctrl: RTL and testbench



---
 rtl/nx_ram_ctrl_pkg.sv | 12 +
 rtl/nx_ram_1rw_port_ctrl_if.sv | 31 +++
 rtl/nx_ram_ctrl_rsp_fifo.sv | 55 +++++
 rtl/nx_ram_1rw_port_ctrl.sv | 130 +++++++++++++
 tb/tb_nx_ram_1rw_port_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/nx_ram_ctrl_pkg.sv
// Shared types and constants for the 1RW RAM port controller.
package nx_ram_ctrl_pkg;

  typedef enum logic [0:0] {StInit, StRun} ctrl_state_e;

  localparam int unsigned RSP_FIFO_DEPTH = 2;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nx_ram_1rw_port_ctrl_if.sv
// Client-side write/read request and read response channels of the RAM port controller.
interface nx_ram_1rw_port_ctrl_if
  import nx_ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = addr_width(256)
);

  logic             wr_vld;
  logic             wr_rdy;
  logic [AW-1:0]    wr_add;
  logic [WIDTH-1:0] wr_dat;
  logic [WIDTH-1:0] wr_bwe;
  logic             rd_vld;
  logic             rd_rdy;
  logic [AW-1:0]    rd_add;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic [WIDTH-1:0] rsp_dat;

  modport master (
    output wr_vld, wr_add, wr_dat, wr_bwe, rd_vld, rd_add, rsp_rdy,
    input  wr_rdy, rd_rdy, rsp_vld, rsp_dat
  );

  modport slave (
    input  wr_vld, wr_add, wr_dat, wr_bwe, rd_vld, rd_add, rsp_rdy,
    output wr_rdy, rd_rdy, rsp_vld, rsp_dat
  );

endinterface

// File: rtl/nx_ram_ctrl_rsp_fifo.sv
// Two-entry flop FIFO with fall-through when empty, so data pushed this cycle is visible at once.
module nx_ram_ctrl_rsp_fifo
  import nx_ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             empty;
  logic             store;
  logic             take;

  assign empty   = (count_q == 2'd0);
  // A push consumed in the same cycle while empty bypasses storage entirely.
  assign store   = push_i & ~(empty & pop_i);
  assign take    = pop_i & ~empty;
  assign vld_o   = ~empty | push_i;
  assign data_o  = empty ? data_i : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q + {1'b0, store} - {1'b0, take};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (take)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= data_i;
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(store && count_q == 2'd2))
    else $error("rsp fifo overflow");

endmodule

// File: rtl/nx_ram_1rw_port_ctrl.sv
// Initiator for a 1RW RAM: post-reset fill, round-robin write/read arbitration and
// a credit-limited, backpressurable read response path.
module nx_ram_1rw_port_ctrl
  import nx_ram_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = 64,
  parameter int unsigned      DEPTH    = 256,
  parameter bit               INIT_ENA = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned     AW       = addr_width(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  nx_ram_1rw_port_ctrl_if.slave  bus_if,
  output logic                   init_done_o,
  output logic                   ram_cs_o,
  output logic                   ram_we_o,
  output logic [AW-1:0]          ram_add_o,
  output logic [WIDTH-1:0]       ram_din_o,
  output logic [WIDTH-1:0]       ram_bwe_o,
  input  logic [WIDTH-1:0]       ram_dout_i
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;  // 0: write favoured on contention
  logic          inflight_q;
  logic          init_done_q;
  logic          wr_gnt, rd_gnt;
  logic          wr_elig, rd_elig;
  logic          credit_ok;
  logic          fifo_vld;
  logic [1:0]    fifo_count;

  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;
  assign wr_elig   = (state_q == StRun) & bus_if.wr_vld;
  assign rd_elig   = (state_q == StRun) & bus_if.rd_vld & credit_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    ram_cs_o  = 1'b0;
    ram_we_o  = 1'b0;
    ram_add_o = '0;
    ram_din_o = '0;
    ram_bwe_o = '0;
    unique case (state_q)
      StInit: begin
        ram_cs_o  = 1'b1;
        ram_we_o  = 1'b1;
        ram_add_o = cnt_q;
        ram_din_o = INIT_VAL;
        ram_bwe_o = '1;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LastAddr) state_d = StRun;
      end
      StRun: begin
        if (wr_elig && (!rd_elig || !rr_q)) begin
          wr_gnt    = 1'b1;
          rr_d      = 1'b1;
          ram_cs_o  = 1'b1;
          ram_we_o  = 1'b1;
          ram_add_o = bus_if.wr_add;
          ram_din_o = bus_if.wr_dat;
          ram_bwe_o = bus_if.wr_bwe;
        end else if (rd_elig) begin
          rd_gnt    = 1'b1;
          rr_d      = 1'b0;
          ram_cs_o  = 1'b1;
          ram_add_o = bus_if.rd_add;
        end
      end
    endcase
    // Nothing leaves the block while reset is held.
    if (rst_i) begin
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      ram_cs_o  = 1'b0;
      ram_we_o  = 1'b0;
      ram_add_o = '0;
      ram_din_o = '0;
      ram_bwe_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT_ENA ? StInit : StRun;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      inflight_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      inflight_q  <= rd_gnt;
      init_done_q <= (state_d == StRun);
    end
  end

  nx_ram_ctrl_rsp_fifo #(
    .WIDTH (WIDTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q & ~rst_i),
    .data_i  (ram_dout_i),
    .pop_i   (bus_if.rsp_rdy & ~rst_i),
    .vld_o   (fifo_vld),
    .data_o  (bus_if.rsp_dat),
    .count_o (fifo_count)
  );

  assign bus_if.wr_rdy  = wr_gnt;
  assign bus_if.rd_rdy  = rd_gnt;
  assign bus_if.rsp_vld = fifo_vld & ~rst_i;
  assign init_done_o    = init_done_q;

  assert property (@(posedge clk_i) disable iff (rst_i) wr_gnt |-> (32'(bus_if.wr_add) < DEPTH))
    else $error("write address beyond DEPTH");
  assert property (@(posedge clk_i) disable iff (rst_i) rd_gnt |-> (32'(bus_if.rd_add) < DEPTH))
    else $error("read address beyond DEPTH");

endmodule

// File: tb/tb_nx_ram_1rw_port_ctrl.sv
// Scoreboard bench for nx_ram_1rw_port_ctrl with a behavioural 1RW RAM attached.
module tb_nx_ram_1rw_port_ctrl;

  localparam int unsigned W = 64;
  localparam int unsigned D = 16;
  localparam int unsigned A = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          ram_cs, ram_we;
  logic [A-1:0]  ram_add;
  logic [W-1:0]  ram_din, ram_bwe;
  logic [W-1:0]  ram_dout = '0;
  logic [W-1:0]  mem [D];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q [$];

  always #5 clk = ~clk;

  nx_ram_1rw_port_ctrl_if #(.WIDTH(W), .AW(A)) bus ();

  nx_ram_1rw_port_ctrl #(
    .WIDTH    (W),
    .DEPTH    (D),
    .INIT_ENA (1'b1),
    .INIT_VAL (64'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus_if      (bus.slave),
    .init_done_o (init_done),
    .ram_cs_o    (ram_cs),
    .ram_we_o    (ram_we),
    .ram_add_o   (ram_add),
    .ram_din_o   (ram_din),
    .ram_bwe_o   (ram_bwe),
    .ram_dout_i  (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_add] <= (mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
      else        ram_dout     <= mem[ram_add];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is compared against the oldest expected value.
  always @(negedge clk) begin
    if (!rst && bus.rsp_vld && bus.rsp_rdy) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_dat, 'x);
      else                   chk("rsp_dat", bus.rsp_dat, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic [W-1:0] be);
    bit got = 1'b0;
    bus.wr_vld = 1'b1; bus.wr_add = a; bus.wr_dat = d; bus.wr_bwe = be;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.wr_rdy;
    end
    chk("wr_accept", 64'(got), 64'd1);
    tick();
    bus.wr_vld = 1'b0;
  endtask

  task automatic do_read(input logic [A-1:0] a, input logic [W-1:0] e);
    bit got = 1'b0;
    bus.rd_vld = 1'b1; bus.rd_add = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.rd_rdy;
    end
    chk("rd_accept", 64'(got), 64'd1);
    if (got) exp_q.push_back(e);
    tick();
    bus.rd_vld = 1'b0;
  endtask

  task automatic check_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({tag, "_add"}, 64'(ram_add), 64'(i));
      chk({tag, "_ctl"}, {ram_cs, ram_we, ram_bwe == '1, ram_din == 64'hA5, init_done},
          64'b11110);
      chk({tag, "_rdy"}, {bus.wr_rdy, bus.rd_rdy, bus.rsp_vld}, 64'b000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit got;
    rst = 1'b1;
    bus.wr_vld = 1'b0; bus.wr_add = '0; bus.wr_dat = '0; bus.wr_bwe = '0;
    bus.rd_vld = 1'b0; bus.rd_add = '0; bus.rsp_rdy = 1'b1;

    // Reset: outputs quiet while held.
    @(negedge clk);
    chk("rst_outs", {ram_cs, init_done, bus.wr_rdy, bus.rd_rdy, bus.rsp_vld}, 64'b0);
    tick();
    rst = 1'b0;
    // Requests pending during init must not be accepted.
    bus.wr_vld = 1'b1; bus.rd_vld = 1'b1;
    check_init("init");
    bus.wr_vld = 1'b0; bus.rd_vld = 1'b0;
    @(negedge clk);
    chk("init_done", 64'(init_done), 64'd1);
    chk("idle_cs", 64'(ram_cs), 64'd0);
    tick();

    do_read(4'd15, 64'hA5);

    // Write then read, one-cycle response latency.
    do_write(4'd3, 64'h1234, '1);
    do_read(4'd3, 64'h1234);
    @(negedge clk);
    chk("lat_vld", 64'(bus.rsp_vld), 64'd1);
    chk("lat_dat", bus.rsp_dat, 64'h1234);
    tick();

    // Bit write enables.
    do_write(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, '1);
    do_write(4'd5, 64'h0, 64'h00FF);
    do_read(4'd5, 64'hFFFF_FFFF_FFFF_FF00);

    do_write(4'd8, 64'h80, '1);
    do_write(4'd9, 64'h81, '1);
    do_write(4'd10, 64'h82, '1);
    do_write(4'd11, 64'h83, '1);
    do_write(4'd14, 64'hE0, '1);
    repeat (3) tick();

    // Backpressure: only two reads may be outstanding while rsp_rdy is low.
    bus.rsp_rdy = 1'b0; n = 0; bus.rd_vld = 1'b1; bus.rd_add = 4'd8;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (c == 6) begin
        chk("bp_accepted", 64'(n), 64'd2);
        bus.rsp_rdy = 1'b1;
      end
      @(negedge clk);
      if (c < 6 && n > 0) begin
        chk("bp_vld", 64'(bus.rsp_vld), 64'd1);
        chk("bp_hold", bus.rsp_dat, 64'h80);
      end
      if (bus.rd_rdy) begin
        exp_q.push_back(64'h80 + 64'(n));
        n++;
      end
      tick();
      if (n == 4) bus.rd_vld = 1'b0;
      else        bus.rd_add = 4'(8 + n);
    end
    chk("bp_all", 64'(n), 64'd4);
    repeat (3) tick();

    // Contention: grants alternate starting with write.
    bus.wr_vld = 1'b1; bus.wr_add = 4'd13; bus.wr_dat = 64'hD00D; bus.wr_bwe = '1;
    bus.rd_vld = 1'b1; bus.rd_add = 4'd14;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ct_cs", 64'(ram_cs), 64'd1);
      chk("ct_wr", 64'(bus.wr_rdy), 64'(c % 2 == 0));
      chk("ct_rd", 64'(bus.rd_rdy), 64'(c % 2 == 1));
      if (bus.rd_rdy) exp_q.push_back(64'hE0);
      tick();
    end
    bus.wr_vld = 1'b0; bus.rd_vld = 1'b0;
    do_read(4'd13, 64'hD00D);
    repeat (3) tick();

    // Reset the cycle after a read grant: its data must never surface.
    bus.rd_vld = 1'b1; bus.rd_add = 4'd3; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.rd_rdy;
    end
    chk("rm_accept", 64'(got), 64'd1);
    tick();
    bus.rd_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_outs", {bus.rsp_vld, ram_cs}, 64'b00);
    tick();
    rst = 1'b0;
    check_init("reinit");
    @(negedge clk);
    chk("rm_done", 64'(init_done), 64'd1);
    chk("rm_vld", 64'(bus.rsp_vld), 64'd0);
    tick();
    do_read(4'd3, 64'hA5);

    repeat (4) tick();
    chk("q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
